// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator; one step per clock.
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

   localparam logic [2:0] OP_MULTU = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_DIVU  = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_res_q, neg_res_d;
   logic                 neg_rem_q, neg_rem_d;
   logic                 zdiv_q, zdiv_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;
   logic                 dz_q, dz_d;

   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [WIDTH-1:0]     mul_add;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_trial;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   mul_res;
   logic [WIDTH-1:0]     quo, rem;

   // Signed ops iterate on magnitudes; signs are reapplied once at FINISH.
   assign a_abs = (op[0] && a[WIDTH-1]) ? -a : a;
   assign b_abs = (op[0] && b[WIDTH-1]) ? -b : b;

   // Multiply: upper half accumulates, lower half shifts the multiplier out.
   assign mul_add  = acc_q[0] ? opb_q : '0;
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: upper half is the partial remainder, lower half dividend/quotient.
   assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
   assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   assign mul_res = neg_res_q ? -acc_q : acc_q;
   assign quo     = acc_q[WIDTH-1:0];
   assign rem     = acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      zdiv_d    = zdiv_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dz_d      = dz_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               unique case (op)
                  OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                     is_div_d  = op[1];
                     neg_res_d = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_rem_d = op[0] & a[WIDTH-1];
                     opb_d     = b_abs;
                     cnt_d     = '0;
                     if (op[1] && (b == '0)) begin
                        // Zero divisor: keep raw dividend for HI and go straight to FINISH.
                        zdiv_d  = 1'b1;
                        acc_d   = {{WIDTH{1'b0}}, a};
                        state_d = FINISH;
                     end else begin
                        zdiv_d  = 1'b0;
                        acc_d   = {{WIDTH{1'b0}}, a_abs};
                        state_d = CALC;
                     end
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         CALC: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) state_d = FINISH;
         end
         FINISH: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (!is_div_q) begin
               hi_d = mul_res[2*WIDTH-1:WIDTH];
               lo_d = mul_res[WIDTH-1:0];
            end else if (zdiv_q) begin
               hi_d = acc_q[WIDTH-1:0];
               lo_d = '1;
               dz_d = 1'b1;
            end else begin
               hi_d = neg_rem_q ? -rem : rem;
               lo_d = neg_res_q ? -quo : quo;
               dz_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         zdiv_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         zdiv_q    <= zdiv_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign dz   = dz_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32): directed corner cases plus
// randomized ops against an arithmetic reference model of HI/LO/dz.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done, dz;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_hi = '0, exp_lo = '0;
   logic        exp_dz = 1'b0;

   mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
   function automatic void ref_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         3'd0: begin p = {32'd0, x} * {32'd0, y}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
         3'd1: begin p = sx * sy; exp_hi = p[63:32]; exp_lo = p[31:0]; end
         3'd2, 3'd3: begin
            if (y == 32'd0) begin
               exp_hi = x; exp_lo = 32'hFFFF_FFFF; exp_dz = 1'b1;
            end else begin
               exp_dz = 1'b0;
               if (o == 3'd2) begin
                  exp_lo = x / y; exp_hi = x % y;
               end else begin
                  p = sx / sy; exp_lo = p[31:0];
                  p = sx % sy; exp_hi = p[31:0];
               end
            end
         end
         3'd4: exp_hi = x;
         3'd5: exp_lo = x;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Called at a falling edge; returns at the falling edge where done is seen.
   // lat counts rising edges from the start edge through the one raising done.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcyc, output bit held);
      logic [31:0] h0, l0;
      h0 = hi; l0 = lo; lat = -1; bcyc = 0; held = 1'b1;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); @(negedge clk);
      start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      for (int k = 1; k <= 100; k++) begin
         if (done) begin lat = k; break; end
         if (busy) bcyc++;
         if (hi !== h0 || lo !== l0) held = 1'b0;
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", dz); end
      n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
      n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_multu_max();
      int lat, bcyc; bit held;
      run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc, held);
      ref_apply(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
      n_checks++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo); end
      n_checks++; if (lat != 34) begin n_fail++; $display("FAIL multu_latency: got %0d want 34", lat); end
      n_checks++; if (bcyc != 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 33", bcyc); end
      n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL multu_hold: got %b want 1", held); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_in_done: got %b want 0", busy); end
      @(posedge clk); @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_mult_signed();
      int lat, bcyc; bit held;
      run_op(3'd1, 32'hFFFF_FFFD, 32'd7, lat, bcyc, held);
      ref_apply(3'd1, 32'hFFFF_FFFD, 32'd7);
      n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
      n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
   endtask

   task automatic test_div_and_zero();
      int lat, bcyc; bit held;
      run_op(3'd3, 32'hFFFF_FFF9, 32'd2, lat, bcyc, held);
      ref_apply(3'd3, 32'hFFFF_FFF9, 32'd2);
      n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo); end
      n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi); end
      n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL div_dz: got %b want 0", dz); end
      run_op(3'd2, 32'd7, 32'd0, lat, bcyc, held);
      ref_apply(3'd2, 32'd7, 32'd0);
      n_checks++; if (hi !== 32'd7) begin n_fail++; $display("FAIL divz_hi: got %h want 7", hi); end
      n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
      n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL divz_dz: got %b want 1", dz); end
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL divz_latency: got %0d want 2", lat); end
   endtask

   task automatic test_div_overflow();
      int lat, bcyc; bit held;
      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc, held);
      ref_apply(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
      n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL divovf_hi: got %h want 0", hi); end
      n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL divovf_dz: got %b want 0", dz); end
   endtask

   task automatic test_mthi();
      start = 1'b1; op = 3'd4; a = 32'h1234_5678; b = $urandom;
      @(posedge clk); @(negedge clk);
      start = 1'b0; a = $urandom;
      ref_apply(3'd4, 32'h1234_5678, 32'd0);
      n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
      n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL mthi_lo: got %h want %h", lo, exp_lo); end
      n_checks++; if (dz !== exp_dz) begin n_fail++; $display("FAIL mthi_dz: got %b want %b", dz, exp_dz); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mthi_done: got %b want 0", done); end
   endtask

   task automatic test_ignore_start();
      logic [31:0] x, y;
      int lat;
      x = $urandom; y = 32'($urandom_range(1, 1000));
      lat = -1;
      start = 1'b1; op = 3'd2; a = x; b = y;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         if (done) begin lat = k; break; end
         // Competing requests mid-flight: must be dropped, not queued.
         start = (k == 5 || k == 12);
         op    = (k == 5) ? 3'd1 : 3'd4;
         a = $urandom; b = $urandom;
         @(posedge clk); @(negedge clk);
      end
      start = 1'b0;
      ref_apply(3'd2, x, y);
      n_checks++; if (lat != 34) begin n_fail++; $display("FAIL ignore_latency: got %0d want 34", lat); end
      n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL ignore_lo: got %h want %h", lo, exp_lo); end
      n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL ignore_hi: got %h want %h", hi, exp_hi); end
      @(posedge clk); @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queue: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_calc();
      int lat, bcyc; bit held, saw_done;
      saw_done = 1'b0;
      start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL rstmid_hi: got %h want 0", hi); end
      n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL rstmid_lo: got %h want 0", lo); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL rstmid_dz: got %b want 0", dz); end
      repeat (3) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got %b want 0", saw_done); end
      rst = 1'b1;
      exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
      run_op(3'd0, 32'd3, 32'd5, lat, bcyc, held);
      ref_apply(3'd0, 32'd3, 32'd5);
      n_checks++; if (lo !== 32'd15) begin n_fail++; $display("FAIL rstmid_next_lo: got %h want f", lo); end
      n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL rstmid_next_hi: got %h want 0", hi); end
      n_checks++; if (lat != 34) begin n_fail++; $display("FAIL rstmid_next_latency: got %0d want 34", lat); end
   endtask

   // Back-to-back: each op starts in the done cycle of the previous one.
   task automatic test_random_back_to_back();
      int lat, bcyc, want_lat; bit held;
      logic [2:0]  o;
      logic [31:0] x, y;
      for (int i = 0; i < 60; i++) begin
         o = 3'($urandom_range(0, 7));
         x = pick_operand();
         y = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
         if (o <= 3'd3) begin
            run_op(o, x, y, lat, bcyc, held);
            want_lat = (o[1] && y == 32'd0) ? 2 : 34;
            ref_apply(o, x, y);
            n_checks++; if (lat != want_lat) begin n_fail++; $display("FAIL rand_latency[%0d] op=%0d: got %0d want %0d", i, o, lat, want_lat); end
            n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL rand_hold[%0d]: got %b want 1", i, held); end
         end else begin
            start = 1'b1; op = o; a = x; b = y;
            @(posedge clk); @(negedge clk);
            start = 1'b0;
            ref_apply(o, x, y);
            n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rand_idle_op[%0d] op=%0d: busy=%b done=%b want 0 0", i, o, busy, done); end
         end
         n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL rand_hi[%0d] op=%0d a=%h b=%h: got %h want %h", i, o, x, y, hi, exp_hi); end
         n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL rand_lo[%0d] op=%0d a=%h b=%h: got %h want %h", i, o, x, y, lo, exp_lo); end
         n_checks++; if (dz !== exp_dz) begin n_fail++; $display("FAIL rand_dz[%0d] op=%0d: got %b want %b", i, o, dz, exp_dz); end
      end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_mult_signed();
      test_div_and_zero();
      test_div_overflow();
      test_mthi();
      test_ignore_start();
      test_reset_mid_calc();
      test_random_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
